alarm_mode_ctrl: RTL

//  Mode/sequence controller for the alarm-clock time datapath (sec/min/hour counters).

---
 rtl/alarm_clk_pkg.sv | 68 ++++++
 rtl/alarm_mode_ctrl_if.sv | 30 +++
 rtl/alarm_time_reg.sv | 54 +++++
 rtl/alarm_mode_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clk_pkg.sv
// Shared types, field limits and helpers for the alarm-clock mode controller.
package alarm_clk_pkg;

  typedef enum logic [2:0] {
    ST_CLOCK,
    ST_ADJ_T_HR,
    ST_ADJ_T_MIN,
    ST_ADJ_A_HR,
    ST_ADJ_A_MIN,
    ST_RINGING
  } state_e;

  localparam logic [5:0] MIN_MAX      = 6'd59;
  localparam logic [4:0] HOUR_MAX     = 5'd23;
  localparam logic [1:0] EN_STEP_MIN  = 2'b11;
  localparam logic [1:0] EN_STEP_HOUR = 2'b10;
  localparam logic [1:0] EN_NONE      = 2'b00;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
  } hm_t;

  function automatic state_e next_field(input state_e s);
    case (s)
      ST_ADJ_T_HR:  return ST_ADJ_T_MIN;
      ST_ADJ_T_MIN: return ST_ADJ_A_HR;
      ST_ADJ_A_HR:  return ST_ADJ_A_MIN;
      default:      return ST_ADJ_T_HR;
    endcase
  endfunction

  function automatic state_e prev_field(input state_e s);
    case (s)
      ST_ADJ_T_HR:  return ST_ADJ_A_MIN;
      ST_ADJ_A_MIN: return ST_ADJ_A_HR;
      ST_ADJ_A_HR:  return ST_ADJ_T_MIN;
      default:      return ST_ADJ_T_HR;
    endcase
  endfunction

  function automatic logic [3:0] mode_led_of(input state_e s);
    case (s)
      ST_ADJ_T_HR:  return 4'b0001;
      ST_ADJ_T_MIN: return 4'b0010;
      ST_ADJ_A_HR:  return 4'b0100;
      ST_ADJ_A_MIN: return 4'b1000;
      default:      return 4'b0000;
    endcase
  endfunction

  // Adds n (< 60) minutes with a single carry into the hour, both fields wrapping.
  function automatic hm_t add_minutes(input logic [4:0] hour, input logic [5:0] min,
                                      input int unsigned n);
    hm_t        r;
    logic [6:0] sum;
    sum = {1'b0, min} + 7'(n);
    if (sum > {1'b0, MIN_MAX}) begin
      r.min  = 6'(sum - 7'd60);
      r.hour = (hour >= HOUR_MAX) ? '0 : hour + 5'd1;
    end else begin
      r.min  = sum[5:0];
      r.hour = hour;
    end
    return r;
  endfunction

endpackage

// File: rtl/alarm_mode_ctrl_if.sv
// Button, switch, time and command signals between the mode controller and its neighbours.
interface alarm_mode_ctrl_if;
  logic       btn_c;
  logic       btn_l;
  logic       btn_r;
  logic       btn_u;
  logic       btn_d;
  logic       alarm_on;
  logic [4:0] time_hour;
  logic [5:0] time_min;
  logic [5:0] time_sec;
  logic       run_en;
  logic       adjust_alarm;
  logic [1:0] en_min_hour;
  logic       up_down;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       buzzer;
  logic [3:0] mode_led;

  modport master (
    input  btn_c, btn_l, btn_r, btn_u, btn_d, alarm_on, time_hour, time_min, time_sec,
    output run_en, adjust_alarm, en_min_hour, up_down, alarm_hour, alarm_min, buzzer, mode_led
  );

  modport slave (
    output btn_c, btn_l, btn_r, btn_u, btn_d, alarm_on, time_hour, time_min, time_sec,
    input  run_en, adjust_alarm, en_min_hour, up_down, alarm_hour, alarm_min, buzzer, mode_led
  );
endinterface

// File: rtl/alarm_time_reg.sv
// Hour:minute register pair, mod-24 / mod-60, with independent up/down steps and a parallel load.
module alarm_time_reg
  import alarm_clk_pkg::*;
#(
  parameter int unsigned RST_HOUR = 0,
  parameter int unsigned RST_MIN  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_min,
  input  logic       step_hour,
  input  logic       up,
  input  logic       load,
  input  logic [4:0] load_hour,
  input  logic [5:0] load_min,
  output logic [4:0] hour,
  output logic [5:0] min
);

  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;

  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    if (load) begin
      hour_d = load_hour;
      min_d  = load_min;
    end else begin
      if (step_min) begin
        if (up) min_d = (min_q >= MIN_MAX) ? '0 : min_q + 6'd1;
        else    min_d = (min_q == '0) ? MIN_MAX : min_q - 6'd1;
      end
      if (step_hour) begin
        if (up) hour_d = (hour_q >= HOUR_MAX) ? '0 : hour_q + 5'd1;
        else    hour_d = (hour_q == '0) ? HOUR_MAX : hour_q - 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hour_q <= 5'(RST_HOUR);
      min_q  <= 6'(RST_MIN);
    end else begin
      hour_q <= hour_d;
      min_q  <= min_d;
    end
  end

  assign hour = hour_q;
  assign min  = min_q;

endmodule

// File: rtl/alarm_mode_ctrl.sv
// Alarm-clock mode/sequence controller: button decode, alarm registers, match and buzzer.
// Optional snooze support is compiled in with `define ALARM_SNOOZE_EN.
module alarm_mode_ctrl
  import alarm_clk_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN     = 5,
  parameter int unsigned ALARM_RST_HOUR = 0,
  parameter int unsigned ALARM_RST_MIN  = 0
) (
  input  logic              clk,
  input  logic              rst,
  alarm_mode_ctrl_if.master bus
);

  if (SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_snooze_min
    $error("SNOOZE_MIN must be 1..59");
  end

  state_e     state_q, state_d;
  logic       run_en_q, run_en_d;
  logic       adjust_alarm_q, adjust_alarm_d;
  logic [1:0] en_min_hour_q, en_min_hour_d;
  logic       up_down_q, up_down_d;
  logic       buzzer_q, buzzer_d;
  logic [3:0] mode_led_q, mode_led_d;
  logic       match_q, match_d;

  logic       al_step_min, al_step_hour, al_up;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [5:0] ring_min;
  logic       alarm_match, snooze_match, match_edge;
  logic       l_act, r_act, u_act, d_act;

  // Opposing buttons pressed together cancel each other.
  assign l_act = bus.btn_l & ~bus.btn_r;
  assign r_act = bus.btn_r & ~bus.btn_l;
  assign u_act = bus.btn_u & ~bus.btn_d;
  assign d_act = bus.btn_d & ~bus.btn_u;

  alarm_time_reg #(
    .RST_HOUR (ALARM_RST_HOUR),
    .RST_MIN  (ALARM_RST_MIN)
  ) u_alarm_reg (
    .clk       (clk),
    .rst       (rst),
    .step_min  (al_step_min),
    .step_hour (al_step_hour),
    .up        (al_up),
    .load      (1'b0),
    .load_hour ('0),
    .load_min  ('0),
    .hour      (alarm_hour),
    .min       (alarm_min)
  );

  assign alarm_match = bus.alarm_on && bus.time_hour == alarm_hour &&
                       bus.time_min == alarm_min && bus.time_sec == '0;

`ifdef ALARM_SNOOZE_EN
  logic       snooze_load;
  logic       snooze_pend_q, snooze_pend_d;
  logic [4:0] snooze_hour;
  logic [5:0] snooze_min;
  logic [4:0] ring_hour_q, ring_hour_d;
  logic [5:0] ring_min_q, ring_min_d;
  hm_t        snooze_tgt;

  // The ring time is latched on ring entry so auto-stop and the next snooze follow whichever
  // target actually fired.
  assign snooze_tgt = add_minutes(ring_hour_q, ring_min_q, SNOOZE_MIN);

  alarm_time_reg #(
    .RST_HOUR (0),
    .RST_MIN  (0)
  ) u_snooze_reg (
    .clk       (clk),
    .rst       (rst),
    .step_min  (1'b0),
    .step_hour (1'b0),
    .up        (1'b1),
    .load      (snooze_load),
    .load_hour (snooze_tgt.hour),
    .load_min  (snooze_tgt.min),
    .hour      (snooze_hour),
    .min       (snooze_min)
  );

  assign snooze_match = snooze_pend_q && bus.alarm_on && bus.time_hour == snooze_hour &&
                        bus.time_min == snooze_min && bus.time_sec == '0;
  assign ring_min     = ring_min_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      snooze_pend_q <= 1'b0;
      ring_hour_q   <= '0;
      ring_min_q    <= '0;
    end else begin
      snooze_pend_q <= snooze_pend_d;
      ring_hour_q   <= ring_hour_d;
      ring_min_q    <= ring_min_d;
    end
  end
`else
  assign snooze_match = 1'b0;
  assign ring_min     = alarm_min;
`endif

  assign match_d    = alarm_match | snooze_match;
  assign match_edge = match_d & ~match_q;

  always_comb begin
    state_d       = state_q;
    en_min_hour_d = EN_NONE;
    up_down_d     = 1'b1;
    al_step_min   = 1'b0;
    al_step_hour  = 1'b0;
    al_up         = u_act;
`ifdef ALARM_SNOOZE_EN
    snooze_load   = 1'b0;
    snooze_pend_d = snooze_pend_q;
    ring_hour_d   = ring_hour_q;
    ring_min_d    = ring_min_q;
`endif
    case (state_q)
      ST_CLOCK: begin
        if (bus.btn_c) begin
          state_d = ST_ADJ_T_HR;
`ifdef ALARM_SNOOZE_EN
          snooze_pend_d = 1'b0;
`endif
        end else if (match_edge) begin
          state_d = ST_RINGING;
`ifdef ALARM_SNOOZE_EN
          snooze_pend_d = 1'b0;
          ring_hour_d   = snooze_match ? snooze_hour : alarm_hour;
          ring_min_d    = snooze_match ? snooze_min  : alarm_min;
`endif
        end
      end
      ST_ADJ_T_HR, ST_ADJ_T_MIN, ST_ADJ_A_HR, ST_ADJ_A_MIN: begin
        if (bus.btn_c) begin
          state_d = ST_CLOCK;
        end else if (r_act) begin
          state_d = next_field(state_q);
        end else if (l_act) begin
          state_d = prev_field(state_q);
        end else if (u_act || d_act) begin
          case (state_q)
            ST_ADJ_T_HR: begin
              en_min_hour_d = EN_STEP_HOUR;
              up_down_d     = u_act;
            end
            ST_ADJ_T_MIN: begin
              en_min_hour_d = EN_STEP_MIN;
              up_down_d     = u_act;
            end
            ST_ADJ_A_HR: al_step_hour = 1'b1;
            default:     al_step_min  = 1'b1;
          endcase
        end
      end
      ST_RINGING: begin
        if (bus.btn_c || !bus.alarm_on || bus.time_min != ring_min) begin
          state_d = ST_CLOCK;
`ifdef ALARM_SNOOZE_EN
          snooze_pend_d = 1'b0;
        end else if (u_act && !l_act && !r_act) begin
          state_d       = ST_CLOCK;
          snooze_load   = 1'b1;
          snooze_pend_d = 1'b1;
`endif
        end
      end
      default: state_d = ST_CLOCK;
    endcase

    run_en_d       = (state_d == ST_CLOCK) || (state_d == ST_RINGING);
    adjust_alarm_d = (state_d == ST_ADJ_A_HR) || (state_d == ST_ADJ_A_MIN);
    buzzer_d       = (state_d == ST_RINGING);
    mode_led_d     = mode_led_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_CLOCK;
      run_en_q       <= 1'b1;
      adjust_alarm_q <= 1'b0;
      en_min_hour_q  <= EN_NONE;
      up_down_q      <= 1'b1;
      buzzer_q       <= 1'b0;
      mode_led_q     <= '0;
      match_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_en_q       <= run_en_d;
      adjust_alarm_q <= adjust_alarm_d;
      en_min_hour_q  <= en_min_hour_d;
      up_down_q      <= up_down_d;
      buzzer_q       <= buzzer_d;
      mode_led_q     <= mode_led_d;
      match_q        <= match_d;
    end
  end

  assign bus.run_en       = run_en_q;
  assign bus.adjust_alarm = adjust_alarm_q;
  assign bus.en_min_hour  = en_min_hour_q;
  assign bus.up_down      = up_down_q;
  assign bus.buzzer       = buzzer_q;
  assign bus.mode_led     = mode_led_q;
  assign bus.alarm_hour   = alarm_hour;
  assign bus.alarm_min    = alarm_min;

endmodule
